li_expander: RTL

- Inverse of the immediate-extension path: takes a 32-bit constant plus a destination register and emits the minimal MIPS instruction sequence that rebuilds that constant in the register.
- Sits between the test-program generator / instruction feeder and instruction memory or the instruction queue.
- Emits one 32-bit instruction word per valid/ready handshake.
- Sequence rules: addiu when the value sign-extends from 16 bits, ori when it zero-extends, otherwise lui followed by an optional ori.

---
 rtl/li_expander.sv | 132 +++++++++++++
 1 files changed

// File: rtl/li_expander.sv
// Constant-load sequence generator: turns a 32-bit value plus destination
// register into the shortest addiu / ori / lui(+ori) MIPS instruction stream.
module li_expander #(
  parameter bit          USE_ADDIU = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_value,
  input  logic [4:0]       in_rt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] emit_cnt
);

  typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_t;

  state_t            state, state_n;
  logic [31:0]       instr_q, instr_n;
  logic [31:0]       second_q, second_n;
  logic              last_q, last_n;
  logic              full_q, full_n;
  logic [CNT_W-1:0]  cnt_q;

  logic              accept, fire;
  logic              is_sign, is_zero, is_hi;
  logic [31:0]       w_addiu, w_ori0, w_lui, w_orirr;

  assign accept = in_valid && in_ready;
  assign fire   = out_valid && out_ready;

  assign is_sign = USE_ADDIU && ((&in_value[31:15]) || !(|in_value[31:15]));
  assign is_zero = !(|in_value[31:16]);
  assign is_hi   = !(|in_value[15:0]);

  assign w_addiu = {6'b001001, 5'd0,  in_rt, in_value[15:0]};
  assign w_ori0  = {6'b001101, 5'd0,  in_rt, in_value[15:0]};
  assign w_lui   = {6'b001111, 5'd0,  in_rt, in_value[31:16]};
  assign w_orirr = {6'b001101, in_rt, in_rt, in_value[15:0]};

  always_comb begin
    state_n  = state;
    instr_n  = instr_q;
    second_n = second_q;
    last_n   = last_q;
    full_n   = full_q;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n  = EMIT1;
          second_n = w_orirr;
          full_n   = 1'b0;
          last_n   = 1'b1;
          if (is_sign) begin
            instr_n = w_addiu;
          end else if (is_zero) begin
            instr_n = w_ori0;
          end else if (is_hi) begin
            instr_n = w_lui;
          end else begin
            instr_n = w_lui;
            last_n  = 1'b0;
            full_n  = 1'b1;
          end
        end
      end
      EMIT1: begin
        if (out_ready) begin
          if (full_q) begin
            state_n = EMIT2;
            instr_n = second_q;
            last_n  = 1'b1;
          end else begin
            state_n = IDLE;
            instr_n = '0;
            last_n  = 1'b0;
          end
        end
      end
      EMIT2: begin
        if (out_ready) begin
          state_n = IDLE;
          instr_n = '0;
          last_n  = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        instr_n = '0;
        last_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Output word and last flag are registered so out_* never depend on in_* or out_ready.
  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_q  <= '0;
      second_q <= '0;
      last_q   <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      instr_q  <= instr_n;
      second_q <= second_n;
      last_q   <= last_n;
      full_q   <= full_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)    cnt_q <= '0;
    else if (fire) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state != IDLE);
  assign busy      = !in_ready;
  assign out_instr = instr_q;
  assign out_last  = last_q;
  assign emit_cnt  = cnt_q;

endmodule
